// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART boot loader: length-prefixed frame from UART RX into memory words.
// Optional trailer checksum byte when UART_LOADER_CHECKSUM_EN is defined.
module uart_loader #(
    parameter logic [7:0]  CFG_A   = 8'h08,
    parameter logic [7:0]  CFG_B   = 8'h00,
    parameter int unsigned MAX_LEN = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        uart_re,
    output logic        uart_we,
    output logic [2:0]  uart_regsel,
    output logic [31:0] uart_din,
    input  logic [31:0] uart_dout,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);
    typedef enum logic [3:0] {
        S_IDLE, S_CFG_A, S_CFG_B, S_CLR_IF, S_POLL_ST, S_POLL_IF, S_POP, S_CAPTURE,
        S_MEM_WR, S_SEND_POLL, S_SEND_LOAD, S_SEND_PUSH, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_HDR, PH_PAY, PH_SUM} phase_t;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = S_POLL_ST;
`else
    localparam state_t AFTER_PAYLOAD = S_SEND_POLL;
`endif

    state_t      state, state_nx;
    phase_t      phase;
    logic [31:0] len, cnt, addr, word;
    logic [1:0]  lane;
    logic [7:0]  tx_byte, sum;

    logic [7:0]  rx_byte;
    logic [31:0] len_nx, cnt_inc;
    logic        line_err, len_bad, pay_last, unused_bits;

    assign rx_byte     = uart_dout[15:8];
    assign len_nx      = {rx_byte, len[31:8]};
    assign cnt_inc     = cnt + 32'd1;
    assign pay_last    = (cnt_inc == len);
    assign line_err    = uart_dout[21] | uart_dout[20];
    assign len_bad     = (len_nx > MAX_LEN);
    assign unused_bits = ^{uart_dout[31:22], uart_dout[19:16], uart_dout[7:0]};

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_valid = (state == S_MEM_WR);
    assign mem_addr  = addr;
    assign mem_wdata = word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        uart_re     = 1'b0;
        uart_we     = 1'b0;
        uart_regsel = 3'd0;
        uart_din    = 32'h0;
        case (state)
            S_IDLE:    if (start) state_nx = S_CFG_A;
            S_CFG_A: begin
                uart_we = 1'b1; uart_regsel = 3'd2; uart_din = {8'h0, CFG_A, 16'h0};
                state_nx = S_CFG_B;
            end
            S_CFG_B: begin
                uart_we = 1'b1; uart_regsel = 3'd3; uart_din = {CFG_B, 24'h0};
                state_nx = S_CLR_IF;
            end
            S_CLR_IF: begin
                uart_we = 1'b1; uart_regsel = 3'd6;
                state_nx = S_POLL_ST;
            end
            S_POLL_ST: begin
                uart_regsel = 3'd5;
                state_nx = uart_dout[14] ? S_POLL_IF : S_POP;
            end
            S_POLL_IF: begin
                uart_regsel = 3'd6;
                state_nx = line_err ? S_SEND_LOAD : S_POLL_ST;
            end
            S_POP: begin
                uart_re = 1'b1; uart_regsel = 3'd1;
                state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                uart_regsel = 3'd1;
                case (phase)
                    PH_HDR: begin
                        if (lane != 2'd3)     state_nx = S_POLL_ST;
                        else if (len_bad)     state_nx = S_SEND_POLL;
                        else if (len_nx == 0) state_nx = AFTER_PAYLOAD;
                        else                  state_nx = S_POLL_ST;
                    end
                    PH_PAY:  state_nx = (lane == 2'd3 || pay_last) ? S_MEM_WR : S_POLL_ST;
                    default: state_nx = S_SEND_POLL;
                endcase
            end
            S_MEM_WR:  if (mem_ready) state_nx = (cnt == len) ? AFTER_PAYLOAD : S_POLL_ST;
            S_SEND_POLL: begin
                uart_regsel = 3'd5;
                if (!uart_dout[15]) state_nx = S_SEND_LOAD;
            end
            S_SEND_LOAD: begin
                uart_we = 1'b1; uart_din = {24'h0, tx_byte};
                state_nx = S_SEND_PUSH;
            end
            S_SEND_PUSH: begin
                uart_re = 1'b1; uart_we = 1'b1; uart_din = {24'h0, tx_byte};
                state_nx = S_DONE;
            end
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Datapath: header shift, payload packing, checksum and response byte selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PH_HDR; len <= '0; cnt <= '0; addr <= '0; word <= '0;
            lane <= '0; tx_byte <= '0; sum <= '0; err_code <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    phase <= PH_HDR; len <= '0; cnt <= '0; addr <= base_addr; word <= '0;
                    lane <= '0; tx_byte <= ACK; sum <= '0; err_code <= 2'd0;
                end
                S_POLL_IF: if (line_err) begin
                    err_code <= 2'd1; tx_byte <= NAK;
                end
                S_CAPTURE: begin
                    case (phase)
                        PH_HDR: begin
                            len  <= len_nx;
                            lane <= lane + 2'd1;
                            if (lane == 2'd3) begin
                                phase <= (len_nx == 0) ? PH_SUM : PH_PAY;
                                if (len_bad) begin
                                    err_code <= 2'd2; tx_byte <= NAK;
                                end
                            end
                        end
                        PH_PAY: begin
                            word[{lane, 3'b000} +: 8] <= rx_byte;
                            sum  <= sum + rx_byte;
                            cnt  <= cnt_inc;
                            lane <= lane + 2'd1;
                            if (pay_last) phase <= PH_SUM;
                        end
                        default: if (rx_byte != sum) begin
                            err_code <= 2'd3; tx_byte <= NAK;
                        end
                    endcase
                end
                S_MEM_WR: if (mem_ready) begin
                    addr <= addr + 32'd4; word <= '0; lane <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
